// File: rtl/vmem_seq_ctrl_if.sv
// Signal bundle between the EX/MEM register, the vector memory sequencer and the data-memory port.
// The sequencer takes the slave view; the pipeline/memory side takes the master view.
interface vmem_seq_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NELEM = 4
);
    localparam int unsigned VlW = (NELEM > 1) ? $clog2(NELEM) : 1;

    logic                    ex_vmem_valid;
    logic                    ex_memwrite;
    logic [VlW-1:0]          ex_VL;
    logic [XLEN-1:0]         ex_addr;
    logic [NELEM*XLEN-1:0]   ex_vwdata;
    logic                    mem_ack;
    logic [XLEN-1:0]         mem_rdata;
    logic                    stall;
    logic                    mem_req;
    logic                    mem_we;
    logic [XLEN-1:0]         mem_addr;
    logic [XLEN-1:0]         mem_wdata;
    logic [NELEM*XLEN-1:0]   vrdata_out;
    logic                    vdone;

    modport master (
        output ex_vmem_valid, ex_memwrite, ex_VL, ex_addr, ex_vwdata, mem_ack, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_wdata, vrdata_out, vdone
    );

    modport slave (
        input  ex_vmem_valid, ex_memwrite, ex_VL, ex_addr, ex_vwdata, mem_ack, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_wdata, vrdata_out, vdone
    );
endinterface

// File: rtl/vmem_seq_ctrl.sv
// Splits a vector load/store held in EX/MEM into VL+1 single-word memory requests,
// stalling the front of the pipeline and gathering load data into a packed vector.
module vmem_seq_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NELEM      = 4,
    parameter int unsigned ELEM_BYTES = 4
) (
    input logic             clk,
    input logic             reset,
    vmem_seq_ctrl_if.slave  bus
);
    localparam int unsigned IdxW = (NELEM > 1) ? $clog2(NELEM) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic [IdxW-1:0]        idx_inc;
    logic                   is_store_q, is_store_d;
    logic [XLEN-1:0]        base_q, base_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [NELEM*XLEN-1:0]  vw_q, vw_d;
    logic [NELEM*XLEN-1:0]  vr_q, vr_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        is_store_d = is_store_q;
        base_d     = base_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        vw_d       = vw_q;
        vr_d       = vr_q;
        idx_inc    = idx_q + 1'b1;
        bus.stall  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Hold the op in EX/MEM on the same edge it is accepted.
                bus.stall = bus.ex_vmem_valid;
                if (bus.ex_vmem_valid) begin
                    base_d     = bus.ex_addr;
                    is_store_d = bus.ex_memwrite;
                    last_d     = bus.ex_VL;
                    vw_d       = bus.ex_vwdata;
                    idx_d      = '0;
                    addr_d     = bus.ex_addr;
                    wdata_d    = bus.ex_vwdata[XLEN-1:0];
                    state_d    = StReq;
                end
            end
            StReq: begin
                bus.stall = 1'b1;
                if (bus.mem_ack) begin
                    if (!is_store_q) begin
                        vr_d[int'(idx_q)*XLEN +: XLEN] = bus.mem_rdata;
                    end
                    if (idx_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_inc;
                        addr_d  = base_q + XLEN'(ELEM_BYTES) * XLEN'(idx_inc);
                        wdata_d = vw_q[int'(idx_inc)*XLEN +: XLEN];
                    end
                end
            end
            StDone: begin
                // Pipeline advances on this edge; a still-asserted valid is the old op.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_q     <= '0;
            is_store_q <= 1'b0;
            base_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            vw_q       <= '0;
            vr_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            is_store_q <= is_store_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            vw_q       <= vw_d;
            vr_q       <= vr_d;
        end
    end

    assign bus.mem_req    = (state_q == StReq);
    assign bus.mem_we     = (state_q == StReq) && is_store_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.vrdata_out = vr_q;
    assign bus.vdone      = (state_q == StDone);
endmodule

// File: tb/tb_vmem_seq_ctrl.sv
// Bench for vmem_seq_ctrl: directed scenarios plus random ops, checked against an
// element-level model of the expected request stream and gathered load vector.
module tb_vmem_seq_ctrl;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NELEM = 4;
    localparam int unsigned EB    = 4;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic            stall;
        logic            vdone;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vmem_seq_ctrl_if #(.XLEN(XLEN), .NELEM(NELEM)) bus ();

    vmem_seq_ctrl #(.XLEN(XLEN), .NELEM(NELEM), .ELEM_BYTES(EB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] model_vr [NELEM];

    function automatic logic [NELEM*XLEN-1:0] model_vec();
        logic [NELEM*XLEN-1:0] v;
        for (int i = 0; i < int'(NELEM); i++) v[i*XLEN +: XLEN] = model_vr[i];
        return v;
    endfunction

    function automatic obs_t sample();
        return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stall, bus.vdone};
    endfunction

    // Entered and left just after a rising edge; leaves ex_vmem_valid asserted.
    task automatic do_op(input string name, input logic store, input logic [1:0] vl,
                         input logic [XLEN-1:0] base, input logic [NELEM*XLEN-1:0] vw,
                         input int wmin, input int wmax);
        obs_t exp, got;
        int   w;
        bus.ex_vmem_valid = 1'b1;
        bus.ex_memwrite   = store;
        bus.ex_VL         = vl;
        bus.ex_addr       = base;
        bus.ex_vwdata     = vw;
        bus.mem_ack       = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0 || bus.vdone !== 1'b0) begin
            fails++;
            $display("FAIL %s accept: stall/req/vdone=%b%b%b expected 100", name,
                     bus.stall, bus.mem_req, bus.vdone);
        end
        @(posedge clk); #1;
        for (int i = 0; i <= int'(vl); i++) begin
            w = int'($urandom_range(wmax, wmin));
            for (int k = 0; k <= w; k++) begin
                bus.mem_ack   = (k == w);
                bus.mem_rdata = $urandom;
                exp = {1'b1, store, base + XLEN'(i * EB), vw[i*XLEN +: XLEN], 1'b1, 1'b0};
                @(negedge clk);
                got = sample();
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL %s elem%0d wait%0d: got %h expected %h", name, i, k, got, exp);
                end
                if (k == w && !store) model_vr[i] = bus.mem_rdata;
                @(posedge clk); #1;
            end
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.mem_req, bus.stall, bus.vdone} !== 3'b001) begin
            fails++;
            $display("FAIL %s done: req/stall/vdone=%b%b%b expected 001", name,
                     bus.mem_req, bus.stall, bus.vdone);
        end
        tests++;
        if (bus.vrdata_out !== model_vec()) begin
            fails++;
            $display("FAIL %s vrdata: got %h expected %h", name, bus.vrdata_out, model_vec());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (sample() !== '0 || bus.vrdata_out !== '0) begin
            fails++;
            $display("FAIL reset: got %h/%h expected all zero", sample(), bus.vrdata_out);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (sample() !== '0) begin
            fails++;
            $display("FAIL reset_idle: got %h expected 0", sample());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_basic();
        do_op("load_vl3", 1'b0, 2'd3, 32'h100,
              {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 0, 0);
        bus.ex_vmem_valid = 1'b0;
    endtask

    task automatic test_store_wait();
        do_op("store_wait", 1'b1, 2'd1, 32'h200, {64'h0, 32'hB, 32'hA}, 2, 2);
        bus.ex_vmem_valid = 1'b0;
    endtask

    task automatic test_wrap();
        do_op("wrap", 1'b0, 2'd1, 32'hFFFF_FFFC, {4{32'h5A5A_0000}}, 0, 1);
        bus.ex_vmem_valid = 1'b0;
    endtask

    task automatic test_spurious_vl0();
        do_op("fill", 1'b0, 2'd3, 32'h400, '0, 0, 0);
        bus.ex_vmem_valid = 1'b0;
        bus.mem_ack       = 1'b1;
        bus.mem_rdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if ({bus.mem_req, bus.stall, bus.vdone} !== 3'b000) begin
            fails++;
            $display("FAIL spurious_ack: req/stall/vdone=%b%b%b expected 000",
                     bus.mem_req, bus.stall, bus.vdone);
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.vrdata_out !== model_vec() || bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL spurious_keep: got %h req=%b expected %h req=0",
                     bus.vrdata_out, bus.mem_req, model_vec());
        end
        @(posedge clk); #1;
        do_op("load_vl0", 1'b0, 2'd0, 32'h500, '0, 0, 2);
        bus.ex_vmem_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_op("b2b_a", 1'b0, 2'd2, 32'h600, '0, 0, 1);
        do_op("b2b_b", 1'b1, 2'd1, 32'h700, {32'h0, 32'h0, 32'hC0DE_0002, 32'hC0DE_0001}, 0, 1);
        bus.ex_vmem_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({bus.mem_req, bus.stall, bus.vdone} !== 3'b000) begin
                fails++;
                $display("FAIL b2b_retrigger c%0d: req/stall/vdone=%b%b%b expected 000", c,
                         bus.mem_req, bus.stall, bus.vdone);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        bus.ex_vmem_valid = 1'b1;
        bus.ex_memwrite   = 1'b0;
        bus.ex_VL         = 2'd3;
        bus.ex_addr       = 32'h300;
        bus.ex_vwdata     = '0;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h304) begin
            fails++;
            $display("FAIL rst_mid_elem1: req=%b addr=%h expected req=1 addr=00000304",
                     bus.mem_req, bus.mem_addr);
        end
        @(posedge clk); #1;
        reset             = 1'b1;
        bus.ex_vmem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < int'(NELEM); i++) model_vr[i] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (sample() !== '0 || bus.vrdata_out !== '0) begin
                fails++;
                $display("FAIL rst_mid c%0d: got %h/%h expected all zero", c, sample(),
                         bus.vrdata_out);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            do_op("random", 1'($urandom), 2'($urandom), $urandom,
                  {$urandom, $urandom, $urandom, $urandom}, 0, 3);
            if ($urandom_range(1, 0) == 1) begin
                bus.ex_vmem_valid = 1'b0;
                repeat ($urandom_range(2, 1)) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus.ex_vmem_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        bus.ex_vmem_valid = 1'b0;
        bus.ex_memwrite   = 1'b0;
        bus.ex_VL         = '0;
        bus.ex_addr       = '0;
        bus.ex_vwdata     = '0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = '0;
        for (int i = 0; i < int'(NELEM); i++) model_vr[i] = '0;
        @(posedge clk); #1;
        test_reset();
        test_load_basic();
        test_store_wait();
        test_wrap();
        test_spurious_vl0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
